// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window feeder.
// Holds the FSM state encoding and the tap-to-bus packing helper.
package conv_pkg;

  localparam int DATA_W      = 8;
  localparam int OFM_W       = 21;
  localparam int KERNEL_TAPS = 9;
  localparam int BUS_W       = DATA_W * KERNEL_TAPS;

  typedef enum logic [2:0] {
    ST_LOAD_W = 3'd0,
    ST_LOAD_P = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EMIT   = 3'd4
  } state_e;

  typedef logic [KERNEL_TAPS-1:0][DATA_W-1:0] taps_t;

  // Tap k lands in bits [8k+7:8k]; tap 0 is IFM_1 / weight 1.
  function automatic logic [BUS_W-1:0] pack_taps(input taps_t taps);
    logic [BUS_W-1:0] bus;
    bus = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      bus[k*DATA_W +: DATA_W] = taps[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/conv_frame_buffer.sv
// IMG_W x IMG_W pixel store written in raster order, with a combinational 3x3 window read.
// A pixel being written in the same cycle is forwarded so the final beat can appear in window (0,0).
module conv_frame_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  localparam int AW   = $clog2(IMG_W * IMG_W),
  localparam int CW   = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [CW-1:0]     row_i,
  input  logic [CW-1:0]     col_i,
  output logic [BUS_W-1:0]  window_o
);

  logic [DATA_W-1:0] mem_q [IMG_W*IMG_W];
  logic [AW-1:0]     rd_addr_s;
  taps_t             taps_s;

  // Pixel storage; intentionally not reset so a restart only rewinds the counters.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Gather the 3x3 neighbourhood rooted at (row_i, col_i).
  always_comb begin
    taps_s    = '0;
    rd_addr_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rd_addr_s = AW'((int'(row_i) + i) * IMG_W + int'(col_i) + j);
        if (we_i && (rd_addr_s == waddr_i)) begin
          taps_s[3*i+j] = wdata_i;
        end else begin
          taps_s[3*i+j] = mem_q[rd_addr_s];
        end
      end
    end
  end

  assign window_o = pack_taps(taps_s);

endmodule

// File: rtl/conv_window_feeder.sv
// Loads 9 weights and an IMG_W x IMG_W frame, then issues every valid 3x3 window to the
// convolution unit one at a time and forwards each 21-bit result in issue order.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              conv_in_valid_o,
  output logic [BUS_W-1:0]  conv_ifm_o,
  output logic [BUS_W-1:0]  conv_wgt_o,
  input  logic              conv_out_valid_i,
  input  logic [OFM_W-1:0]  conv_ofm_i,
  output logic              res_valid_o,
  output logic [OFM_W-1:0]  res_data_o,
  output logic              res_last_o,
  output logic              busy_o
);

  localparam int AW = $clog2(IMG_W * IMG_W);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST_RC  = CW'(IMG_W - 3);
  localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_W - 1);
  localparam logic [AW-1:0] LAST_WGT = AW'(KERNEL_TAPS - 1);

  state_e             state_q;
  taps_t              wgt_q;
  logic [AW-1:0]      load_cnt_q;
  logic [CW-1:0]      row_q, col_q, row_d, col_d;
  logic               s_ready_q, conv_in_valid_q, res_valid_q, res_last_q, busy_q;
  logic [BUS_W-1:0]   conv_ifm_q, conv_wgt_q;
  logic [OFM_W-1:0]   res_data_q;
  logic               accept_s, pix_we_s, last_win_s;
  logic [BUS_W-1:0]   window_s;

  // Handshake decode and next window position; the buffer is read at the next position.
  always_comb begin
    accept_s   = s_valid_i && s_ready_q;
    pix_we_s   = accept_s && (state_q == ST_LOAD_P);
    last_win_s = (row_q == LAST_RC) && (col_q == LAST_RC);
    row_d      = row_q;
    col_d      = col_q;
    if (state_q == ST_EMIT) begin
      if (col_q == LAST_RC) begin
        col_d = '0;
        row_d = last_win_s ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  conv_frame_buffer #(.IMG_W(IMG_W)) u_frame_buffer (
    .clk      (clk),
    .we_i     (pix_we_s),
    .waddr_i  (load_cnt_q),
    .wdata_i  (s_data_i),
    .row_i    (row_d),
    .col_i    (col_d),
    .window_o (window_s)
  );

  // Main control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_LOAD_W;
      wgt_q           <= '0;
      load_cnt_q      <= '0;
      row_q           <= '0;
      col_q           <= '0;
      s_ready_q       <= 1'b1;
      conv_in_valid_q <= 1'b0;
      conv_ifm_q      <= '0;
      conv_wgt_q      <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_last_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      conv_in_valid_q <= 1'b0;
      res_valid_q     <= 1'b0;
      res_last_q      <= 1'b0;
      case (state_q)
        ST_LOAD_W: begin
          if (accept_s) begin
            // Shift in from the top so the first beat ends up as weight 1.
            wgt_q <= {s_data_i, wgt_q[KERNEL_TAPS-1:1]};
            if (load_cnt_q == LAST_WGT) begin
              load_cnt_q <= '0;
              state_q    <= ST_LOAD_P;
            end else begin
              load_cnt_q <= load_cnt_q + AW'(1);
            end
          end
        end
        ST_LOAD_P: begin
          if (accept_s) begin
            if (load_cnt_q == LAST_PIX) begin
              load_cnt_q      <= '0;
              state_q         <= ST_ISSUE;
              s_ready_q       <= 1'b0;
              busy_q          <= 1'b1;
              conv_in_valid_q <= 1'b1;
              conv_ifm_q      <= window_s;
              conv_wgt_q      <= pack_taps(wgt_q);
            end else begin
              load_cnt_q <= load_cnt_q + AW'(1);
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (conv_out_valid_i) begin
            res_data_q  <= conv_ofm_i;
            res_valid_q <= 1'b1;
            res_last_q  <= last_win_s;
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          row_q <= row_d;
          col_q <= col_d;
          if (last_win_s) begin
            state_q   <= ST_LOAD_W;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state_q         <= ST_ISSUE;
            conv_in_valid_q <= 1'b1;
            conv_ifm_q      <= window_s;
            conv_wgt_q      <= pack_taps(wgt_q);
          end
        end
        default: begin
          state_q   <= ST_LOAD_W;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready_o       = s_ready_q;
  assign conv_in_valid_o = conv_in_valid_q;
  assign conv_ifm_o      = conv_ifm_q;
  assign conv_wgt_o      = conv_wgt_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_last_o      = res_last_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder at IMG_W=4 with a behavioural convolution unit
// of programmable latency standing in for the real one.
module tb_conv_window_feeder;
  import conv_pkg::*;

  localparam int IMG_W = 4;

  typedef struct packed {
    logic             last;
    logic [OFM_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              conv_in_valid_o;
  logic [BUS_W-1:0]  conv_ifm_o;
  logic [BUS_W-1:0]  conv_wgt_o;
  logic              conv_out_valid_i;
  logic [OFM_W-1:0]  conv_ofm_i;
  logic              res_valid_o;
  logic [OFM_W-1:0]  res_data_o;
  logic              res_last_o;
  logic              busy_o;

  exp_t exp_q[$];
  exp_t exp_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat = 4;
  int   rst_gen = 0;
  int   issue_cnt = 0;
  int   last_issue_cyc = -1;
  logic prev_civ = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_feeder #(.IMG_W(IMG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid_i        (s_valid_i),
    .s_data_i         (s_data_i),
    .s_ready_o        (s_ready_o),
    .conv_in_valid_o  (conv_in_valid_o),
    .conv_ifm_o       (conv_ifm_o),
    .conv_wgt_o       (conv_wgt_o),
    .conv_out_valid_i (conv_out_valid_i),
    .conv_ofm_i       (conv_ofm_i),
    .res_valid_o      (res_valid_o),
    .res_data_o       (res_data_o),
    .res_last_o       (res_last_o),
    .busy_o           (busy_o)
  );

  task automatic check_val(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural convolution unit: samples a window, answers lat cycles later.
  always begin : unit_model
    logic [BUS_W-1:0] ifm_cap, wgt_cap;
    logic [OFM_W-1:0] acc;
    int               my_gen;
    @(negedge clk);
    if (rst_n && conv_in_valid_o) begin
      ifm_cap = conv_ifm_o;
      wgt_cap = conv_wgt_o;
      my_gen  = rst_gen;
      acc     = '0;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        acc = acc + OFM_W'(ifm_cap[k*DATA_W +: DATA_W]) * OFM_W'(wgt_cap[k*DATA_W +: DATA_W]);
      end
      repeat (lat) @(posedge clk);
      #1;
      if (my_gen == rst_gen) begin
        check_val("ifm_stable", conv_ifm_o, ifm_cap);
        conv_out_valid_i = 1'b1;
        conv_ofm_i       = acc;
        @(posedge clk);
        #1;
        conv_out_valid_i = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard pops, issue spacing, pulse width and busy backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid_o) begin
        if (exp_q.size() == 0) begin
          check_val("res_unexpected", res_valid_o, 1'b0);
        end else begin
          exp_e = exp_q.pop_front();
          check_val("res_data", res_data_o, exp_e.data);
          check_val("res_last", res_last_o, exp_e.last);
        end
        if (res_last_o) last_issue_cyc = -1;
      end
      if (conv_in_valid_o) begin
        issue_cnt++;
        check_val("ivalid_width", prev_civ, 1'b0);
        if (last_issue_cyc >= 0) check_val("issue_period", cyc - last_issue_cyc, lat + 2);
        last_issue_cyc = cyc;
      end
      if (busy_o) check_val("s_ready_busy", s_ready_o, 1'b0);
    end
    prev_civ = conv_in_valid_o;
  end

  task automatic push_exp(input logic [OFM_W-1:0] v0, input logic [OFM_W-1:0] v1,
                          input logic [OFM_W-1:0] v2, input logic [OFM_W-1:0] v3);
    exp_t e;
    e.last = 1'b0; e.data = v0; exp_q.push_back(e);
    e.data = v1; exp_q.push_back(e);
    e.data = v2; exp_q.push_back(e);
    e.last = 1'b1; e.data = v3; exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] b, input int gap_pct);
    bit rdy;
    int guard;
    if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      s_valid_i = 1'b0;
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
    end
    s_valid_i = 1'b1;
    s_data_i  = b;
    guard     = 0;
    rdy       = 1'b0;
    do begin
      @(negedge clk);
      rdy = s_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 300);
    if (!rdy) check_val("s_ready_timeout", rdy, 1'b1);
  endtask

  // Bytes lo..hi of a frame: index <9 are weights, the rest pixels.
  task automatic send_range(input int lo, input int hi, input logic [DATA_W-1:0] wfill, input bit wramp,
                            input logic [DATA_W-1:0] pfill, input bit pramp, input int gap_pct);
    logic [DATA_W-1:0] b;
    for (int i = lo; i <= hi; i++) begin
      if (i < KERNEL_TAPS) b = wramp ? DATA_W'(i + 1) : wfill;
      else                 b = pramp ? DATA_W'(i - KERNEL_TAPS) : pfill;
      send_byte(b, gap_pct);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_s_ready"}, s_ready_o, 1'b1);
    check_val({tag, "_busy"}, busy_o, 1'b0);
    check_val({tag, "_civ"}, conv_in_valid_o, 1'b0);
    check_val({tag, "_ifm"}, conv_ifm_o, '0);
    check_val({tag, "_wgt"}, conv_wgt_o, '0);
    check_val({tag, "_rvalid"}, res_valid_o, 1'b0);
    check_val({tag, "_rdata"}, res_data_o, '0);
    check_val({tag, "_rlast"}, res_last_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    conv_out_valid_i = 1'b0; conv_ofm_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, unit weights, 4-cycle unit.
    lat = 4; issue_cnt = 0;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    send_range(0, 24, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    wait_drain(200);
    check_val("s1_issues", issue_cnt, 4);

    // Saturated inputs through the full 21-bit path.
    issue_cnt = 0;
    push_exp(21'd585225, 21'd585225, 21'd585225, 21'd585225);
    send_range(0, 24, 8'd255, 1'b0, 8'd255, 1'b0, 0);
    s_valid_i = 1'b0;
    wait_drain(200);

    // Slow unit and gappy source.
    lat = 10; issue_cnt = 0;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    send_range(0, 24, 8'd1, 1'b0, 8'd0, 1'b1, 30);
    s_valid_i = 1'b0;
    wait_drain(400);
    check_val("s3_issues", issue_cnt, 4);

    // Continuous s_valid across two frames; second frame has weights 1..9.
    lat = 4; issue_cnt = 0;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    push_exp(21'd303, 21'd348, 21'd483, 21'd528);
    send_range(0, 24, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    send_range(0, 24, 8'd0, 1'b1, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    wait_drain(400);
    check_val("s4_issues", issue_cnt, 8);

    // Stray result during pixel load must be ignored.
    issue_cnt = 0;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    send_range(0, 13, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    conv_ofm_i = 21'd123; conv_out_valid_i = 1'b1;
    @(posedge clk); #1;
    conv_out_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("stray_busy", busy_o, 1'b0);
      check_val("stray_ready", s_ready_o, 1'b1);
      check_val("stray_rvalid", res_valid_o, 1'b0);
    end
    @(posedge clk); #1;
    send_range(14, 24, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    wait_drain(200);

    // Reset while waiting on window 2, then a clean frame.
    issue_cnt = 0;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    send_range(0, 24, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    for (int n = 0; n < 100 && issue_cnt < 2; n++) begin
      @(posedge clk); #1;
    end
    check_val("s6_reached_w2", issue_cnt, 2);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    conv_out_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_issue_cyc = -1;
    issue_cnt = 0;
    @(posedge clk); #1;
    push_exp(21'd45, 21'd54, 21'd81, 21'd90);
    send_range(0, 24, 8'd1, 1'b0, 8'd0, 1'b1, 0);
    s_valid_i = 1'b0;
    wait_drain(200);
    check_val("s6_issues", issue_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
